mem_bus_arbiter: RTL and testbench
==================================

# mem_bus_arbiter

Two-port arbiter sharing one single-ported 16-bit memory bus between the CPU instruction-fetch port and the data port. Each requester sees the same `re`/`needWait` wait-state handshake the memory presents. Transactions are serialised with a mandatory one-cycle idle gap on the memory side, because memories on this bus only re-arm their completion flag after `re` drops.

## Interface
- No parameters; data and address widths are fixed at 16 bits.
- `clk` input 1: system clock; all state changes on the rising edge.
- `rst_n` input 1: reset, synchronous and active-low.
- `if_addr_i` input 16: fetch address.
- `if_re_i` input 1: fetch read request.
- `if_data_o` output 16: fetch read data.
- `if_needWait_o` output 1: fetch port stall.
- `dm_addr_i` input 16: data-port address.
- `dm_re_i` input 1: data-port read request.
- `dm_we_i` input 1: data-port write request; wins over `dm_re_i` if both are high.
- `dm_data_i` input 16: write data.
- `dm_data_o` output 16: data-port read data.
- `dm_needWait_o` output 1: data port stall.
- `mem_addr_o` output 16: memory address.
- `mem_re_o` output 1: memory read strobe.
- `mem_we_o` output 1: memory write strobe.
- `mem_data_io` inout 16: driven with the latched write data while `mem_we_o`=1, otherwise high-Z.
- `mem_needWait_i` input 1: memory stall.

## Operation
- States: IDLE, BUSY, DONE.
- **IDLE**
  - `mem_re_o`=`mem_we_o`=0.
  - A port is eligible when its request is high and its done flag is clear.
  - If any port is eligible: latch grant, address, direction and write data, then go to BUSY.
- **BUSY**
  - Drive `mem_addr_o` and the latched strobe.
  - When `mem_needWait_i`=0 is sampled while the strobe is high:
    - capture `mem_data_io` into the granted port's read-data register (reads only);
    - set the granted port's done flag;
    - go to DONE.
- **DONE**
  - Strobes low for exactly one cycle, then go to IDLE.
- **Port stall and done flags**
  - `xx_needWait_o = (request high) & !done_flag`, combinational.
  - A done flag clears in any cycle its port's request is low.
  - A requester must drop its request for at least one cycle before issuing the next transaction. A request held high after completion is not re-served.
- Read-data registers hold their value until the next completed read on that port.
- Address and data are latched at grant. Requester changes during BUSY are ignored.
- **Arbitration:** fixed priority, data port over fetch port, unless round-robin is compiled in (see Configuration).
- **Reset** (`rst_n`=0 at a rising edge), including mid-transaction:
  - state → IDLE; strobes low; `mem_data_io` high-Z;
  - done flags clear; read-data registers 0x0000;
  - round-robin pointer favours the data port.
- **Outputs after reset:**
  - `mem_re_o`=0, `mem_we_o`=0, `mem_addr_o`=0x0000;
  - `if_data_o`=`dm_data_o`=0x0000;
  - `needWait` outputs follow their request inputs (done flags clear).

## Timing
- Cycle 0: request seen in IDLE.
- Cycle 1: BUSY, strobe high.
- A memory that stalls W cycles drops `mem_needWait_i` in cycle 1+W.
- Cycle 2+W: DONE. Read data is valid and the port's `needWait_o` is low from this cycle.
- Minimum latency with W=1: request to `needWait_o`=0 in 3 cycles. Bus occupancy is 3+W cycles per transaction, including the gap cycle.
- A second port's pending request is granted in the IDLE cycle following DONE. Its strobe rises two cycles after the first strobe fell.
- Simultaneous requests in IDLE: one grant only. The loser stalls with `needWait_o`=1 throughout.
- A request that drops mid-BUSY does not abort the transaction. The transaction completes and the done flag clears immediately.

## Configuration
- `ARB_ROUND_ROBIN_EN` defined:
  - Round-robin arbitration: after each completed grant, priority passes to the other port.
  - A lone requester is always served.
- Undefined: fixed priority, data port wins every conflict. The fetch port can starve under back-to-back data traffic.

## Test plan
- Single fetch, memory returns 0x0bb6 at 0x0000 with W=1 -> `mem_re_o` high cycles 1–2, `if_needWait_o` low in cycle 3, `if_data_o`=0x0bb6, `mem_re_o`=0 in cycle 3.
- Data write 0x1234 to 0x0010 -> `mem_we_o`=1 with `mem_data_io`=0x1234 until `mem_needWait_i` low; bus high-Z afterwards; `dm_data_o` unchanged.
- Fetch (0x0002, expect 0x0102) and data read (0x0004, expect 0x0326) asserted in the same cycle, fixed priority -> data served first, one idle cycle, then fetch; both results correct.
- Same as the previous case with `ARB_ROUND_ROBIN_EN` and 4 back-to-back request pairs -> grants alternate dm, if, dm, if…
- `if_re_i` held high after completion -> no second `mem_re_o` pulse; drop for 1 cycle and re-raise -> new transaction.
- `rst_n` low during BUSY -> next cycle IDLE, strobes 0, `mem_data_io` Z, data outputs 0x0000; release reset and the pending request is re-served from scratch.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
// Arbiter sharing one single-ported 16-bit memory bus between the fetch port and the data port.
// Define ARB_ROUND_ROBIN_EN for alternating priority; otherwise the data port always wins.
module mem_bus_arbiter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] if_addr_i,
  input  logic        if_re_i,
  output logic [15:0] if_data_o,
  output logic        if_needWait_o,
  input  logic [15:0] dm_addr_i,
  input  logic        dm_re_i,
  input  logic        dm_we_i,
  input  logic [15:0] dm_data_i,
  output logic [15:0] dm_data_o,
  output logic        dm_needWait_o,
  output logic [15:0] mem_addr_o,
  output logic        mem_re_o,
  output logic        mem_we_o,
  inout  wire  [15:0] mem_data_io,
  input  logic        mem_needWait_i
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t      state;
  state_t      state_next;

  logic        grant_dm;
  logic        lat_we;
  logic [15:0] lat_addr;
  logic [15:0] lat_wdata;
  logic        if_done;
  logic        dm_done;
  logic [15:0] if_rdata;
  logic [15:0] dm_rdata;

  logic        if_req;
  logic        dm_req;
  logic        if_elig;
  logic        dm_elig;
  logic        pick_dm;
  logic        start;
  logic        complete;

  assign if_req  = if_re_i;
  assign dm_req  = dm_re_i | dm_we_i;
  assign if_elig = if_req & ~if_done;
  assign dm_elig = dm_req & ~dm_done;

`ifdef ARB_ROUND_ROBIN_EN
  logic rr_dm_first;

  assign pick_dm = dm_elig & (~if_elig | rr_dm_first);

  // Priority passes to the other port after every completed transaction.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_dm_first <= 1'b1;
    end else if (complete) begin
      rr_dm_first <= ~grant_dm;
    end
  end
`else
  assign pick_dm = dm_elig;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    start      = 1'b0;
    complete   = 1'b0;
    mem_re_o   = 1'b0;
    mem_we_o   = 1'b0;
    case (state)
      IDLE: begin
        if (if_elig | dm_elig) begin
          start      = 1'b1;
          state_next = BUSY;
        end
      end
      BUSY: begin
        mem_re_o = ~lat_we;
        mem_we_o = lat_we;
        if (!mem_needWait_i) begin
          complete   = 1'b1;
          state_next = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // A done flag drops whenever its request is low, even in the completion cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      grant_dm  <= 1'b0;
      lat_we    <= 1'b0;
      lat_addr  <= 16'h0000;
      lat_wdata <= 16'h0000;
      if_done   <= 1'b0;
      dm_done   <= 1'b0;
      if_rdata  <= 16'h0000;
      dm_rdata  <= 16'h0000;
    end else begin
      if (start) begin
        grant_dm  <= pick_dm;
        lat_we    <= pick_dm & dm_we_i;
        lat_addr  <= pick_dm ? dm_addr_i : if_addr_i;
        lat_wdata <= dm_data_i;
      end
      if (complete && !lat_we) begin
        if (grant_dm) begin
          dm_rdata <= mem_data_io;
        end else begin
          if_rdata <= mem_data_io;
        end
      end
      if_done <= if_req & (if_done | (complete & ~grant_dm));
      dm_done <= dm_req & (dm_done | (complete & grant_dm));
    end
  end

  assign mem_addr_o    = lat_addr;
  assign mem_data_io   = mem_we_o ? lat_wdata : 16'hzzzz;
  assign if_data_o     = if_rdata;
  assign dm_data_o     = dm_rdata;
  assign if_needWait_o = if_req & ~if_done;
  assign dm_needWait_o = dm_req & ~dm_done;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: a table of single transactions, then hand-written
// sequences for hold-high requests, reset mid-transaction, simultaneous requests and streams.
module tb_mem_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] if_addr;
  logic        if_re;
  logic [15:0] if_data;
  logic        if_need_wait;
  logic [15:0] dm_addr;
  logic        dm_re;
  logic        dm_we;
  logic [15:0] dm_wdata;
  logic [15:0] dm_data;
  logic        dm_need_wait;
  logic [15:0] mem_addr;
  logic        mem_re;
  logic        mem_we;
  wire  [15:0] mem_data;
  logic        mem_need_wait;

  logic [15:0] memory [0:255];
  logic [15:0] bus_keep;
  int          wait_cycles;
  int          strobe_cnt;
  logic        prev_strobe;
  logic [15:0] grant_log [0:63];
  int          grant_cnt;
  int          n_checks;
  int          n_fail;

  typedef struct {
    logic        is_dm;
    logic        re;
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
    int          w;
    int          exp_lat;
    logic [15:0] exp_if;
    logic [15:0] exp_dm;
  } vec_t;

  vec_t vecs [7];

  always #5 clk = ~clk;

  mem_bus_arbiter dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .if_addr_i      (if_addr),
    .if_re_i        (if_re),
    .if_data_o      (if_data),
    .if_needWait_o  (if_need_wait),
    .dm_addr_i      (dm_addr),
    .dm_re_i        (dm_re),
    .dm_we_i        (dm_we),
    .dm_data_i      (dm_wdata),
    .dm_data_o      (dm_data),
    .dm_needWait_o  (dm_need_wait),
    .mem_addr_o     (mem_addr),
    .mem_re_o       (mem_re),
    .mem_we_o       (mem_we),
    .mem_data_io    (mem_data),
    .mem_needWait_i (mem_need_wait)
  );

  // Memory model: drives read data (or a 0xdead marker when idle) whenever the arbiter is not writing.
  assign bus_keep      = mem_re ? memory[mem_addr[7:0]] : 16'hdead;
  assign mem_data      = mem_we ? 16'hzzzz : bus_keep;
  assign mem_need_wait = (mem_re | mem_we) && (strobe_cnt < wait_cycles);

  initial begin
    for (int i = 0; i < 256; i++) memory[i] <= 16'h0000;
    memory[0] <= 16'h0bb6;
    memory[2] <= 16'h0102;
    memory[4] <= 16'h0326;
  end

  always @(posedge clk) begin
    strobe_cnt <= (mem_re | mem_we) ? strobe_cnt + 1 : 0;
    if (mem_we && !mem_need_wait) memory[mem_addr[7:0]] <= mem_data;
  end

  // Record the address of every transaction as its strobe rises.
  always @(negedge clk) begin
    prev_strobe <= mem_re | mem_we;
    if ((mem_re | mem_we) && !prev_strobe && grant_cnt < 64) begin
      grant_log[grant_cnt] <= mem_addr;
      grant_cnt            <= grant_cnt + 1;
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic waitDone(input logic is_dm, output int lat);
    lat = -1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if ((is_dm ? dm_need_wait : if_need_wait) == 1'b0) begin
        lat = c;
        break;
      end
      tick();
    end
  endtask

  // Issue one transaction, observe the bus every cycle, then release the request.
  task automatic applyStimulus(input vec_t v, output int lat, output int strobes,
                               output logic bus_ok, output logic released);
    wait_cycles = v.w;
    if (v.is_dm) begin
      dm_addr  = v.addr;
      dm_wdata = v.wdata;
      dm_re    = v.re;
      dm_we    = v.we;
    end else begin
      if_addr = v.addr;
      if_re   = 1'b1;
    end
    lat      = -1;
    strobes  = 0;
    bus_ok   = 1'b1;
    released = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (mem_re | mem_we) begin
        strobes++;
        if (mem_addr !== v.addr || mem_we !== v.we || mem_re !== !v.we) bus_ok = 1'b0;
        if (v.we && mem_data !== v.wdata) bus_ok = 1'b0;
      end
      if ((v.is_dm ? dm_need_wait : if_need_wait) == 1'b0) begin
        lat      = c;
        released = !(mem_re | mem_we) && (mem_data === 16'hdead);
        break;
      end
      tick();
    end
    tick();
    if_re = 1'b0;
    dm_re = 1'b0;
    dm_we = 1'b0;
    tick();
  endtask

  initial begin
    int          lat;
    int          lat_dm;
    int          lat_if;
    int          strobes;
    int          g;
    int          to_dm;
    int          to_if;
    logic        bus_ok;
    logic        released;
    logic        stuck;
    logic [15:0] exp_order [8];

    n_checks    = 0;
    n_fail      = 0;
    rst_n       = 1'b0;
    if_addr     = 16'h0000;
    if_re       = 1'b1;
    dm_addr     = 16'h0000;
    dm_re       = 1'b0;
    dm_we       = 1'b0;
    dm_wdata    = 16'h0000;
    wait_cycles = 1;

    //                 is_dm re    we    addr      wdata     w  lat if_data   dm_data
    vecs[0] = '{1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000, 1, 3, 16'h0bb6, 16'h0000};
    vecs[1] = '{1'b1, 1'b0, 1'b1, 16'h0010, 16'h1234, 2, 4, 16'h0bb6, 16'h0000};
    vecs[2] = '{1'b1, 1'b1, 1'b0, 16'h0010, 16'h0000, 0, 2, 16'h0bb6, 16'h1234};
    vecs[3] = '{1'b0, 1'b1, 1'b0, 16'h0002, 16'h0000, 3, 5, 16'h0102, 16'h1234};
    vecs[4] = '{1'b1, 1'b1, 1'b0, 16'h0004, 16'h0000, 1, 3, 16'h0102, 16'h0326};
    vecs[5] = '{1'b1, 1'b1, 1'b1, 16'h0006, 16'ha5a5, 1, 3, 16'h0102, 16'h0326};
    vecs[6] = '{1'b1, 1'b1, 1'b0, 16'h0006, 16'h0000, 2, 4, 16'h0102, 16'ha5a5};

`ifdef ARB_ROUND_ROBIN_EN
    exp_order = '{16'h0004, 16'h0002, 16'h0004, 16'h0002, 16'h0004, 16'h0002, 16'h0004, 16'h0002};
`else
    exp_order = '{16'h0004, 16'h0004, 16'h0004, 16'h0004, 16'h0002, 16'h0002, 16'h0002, 16'h0002};
`endif

    $display("[TB] reset state");
    tick();
    tick();
    @(negedge clk);
    checkOutput("reset mem_re", mem_re, 1'b0);
    checkOutput("reset mem_we", mem_we, 1'b0);
    checkOutput("reset mem_addr", mem_addr, 16'h0000);
    checkOutput("reset if_data", if_data, 16'h0000);
    checkOutput("reset dm_data", dm_data, 16'h0000);
    checkOutput("reset if_needWait follows request", if_need_wait, 1'b1);
    checkOutput("reset dm_needWait follows request", dm_need_wait, 1'b0);
    checkOutput("reset bus released", mem_data, 16'hdead);
    if_re = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();

    $display("[TB] single-transaction table");
    foreach (vecs[i]) begin
      applyStimulus(vecs[i], lat, strobes, bus_ok, released);
      checkOutput($sformatf("vec%0d latency", i), lat, vecs[i].exp_lat);
      checkOutput($sformatf("vec%0d strobe cycles", i), strobes, vecs[i].w + 1);
      checkOutput($sformatf("vec%0d bus contents", i), bus_ok, 1'b1);
      checkOutput($sformatf("vec%0d bus released in gap", i), released, 1'b1);
      checkOutput($sformatf("vec%0d if_data", i), if_data, vecs[i].exp_if);
      checkOutput($sformatf("vec%0d dm_data", i), dm_data, vecs[i].exp_dm);
      if (vecs[i].we) begin
        checkOutput($sformatf("vec%0d memory written", i), memory[vecs[i].addr[7:0]], vecs[i].wdata);
      end
    end

    $display("[TB] fetch request held high after completion");
    wait_cycles = 1;
    if_addr     = 16'h0000;
    if_re       = 1'b1;
    waitDone(1'b0, lat);
    checkOutput("hold first latency", lat, 3);
    tick();
    g     = grant_cnt;
    stuck = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (if_need_wait || mem_re || mem_we) stuck = 1'b1;
      tick();
    end
    checkOutput("hold no reissue", grant_cnt - g, 0);
    checkOutput("hold stall stays low", stuck, 1'b0);
    checkOutput("hold if_data", if_data, 16'h0bb6);
    if_re = 1'b0;
    tick();
    if_re = 1'b1;
    waitDone(1'b0, lat);
    checkOutput("hold reissue latency", lat, 3);
    tick();
    checkOutput("hold reissue grants", grant_cnt - g, 1);
    if_re = 1'b0;
    tick();
    tick();

    $display("[TB] reset during BUSY");
    g           = grant_cnt;
    wait_cycles = 5;
    dm_addr     = 16'h0004;
    dm_re       = 1'b1;
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    @(negedge clk);
    checkOutput("midreset mem_re", mem_re, 1'b0);
    checkOutput("midreset mem_we", mem_we, 1'b0);
    checkOutput("midreset mem_addr", mem_addr, 16'h0000);
    checkOutput("midreset bus released", mem_data, 16'hdead);
    checkOutput("midreset if_data", if_data, 16'h0000);
    checkOutput("midreset dm_data", dm_data, 16'h0000);
    checkOutput("midreset dm_needWait", dm_need_wait, 1'b1);
    rst_n       = 1'b1;
    wait_cycles = 1;
    tick();
    waitDone(1'b1, lat);
    checkOutput("midreset reissue latency", lat, 2);
    tick();
    checkOutput("midreset reissue data", dm_data, 16'h0326);
    checkOutput("midreset grant count", grant_cnt - g, 2);
    dm_re = 1'b0;
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();

    $display("[TB] simultaneous fetch and data read");
    g       = grant_cnt;
    if_addr = 16'h0002;
    if_re   = 1'b1;
    dm_addr = 16'h0004;
    dm_re   = 1'b1;
    lat_dm  = -1;
    lat_if  = -1;
    for (int c = 0; c < 30 && (lat_dm < 0 || lat_if < 0); c++) begin
      @(negedge clk);
      if (lat_dm < 0 && !dm_need_wait) begin
        lat_dm = c;
        dm_re  = 1'b0;
      end
      if (lat_if < 0 && !if_need_wait) begin
        lat_if = c;
        if_re  = 1'b0;
      end
      tick();
    end
    if_re = 1'b0;
    dm_re = 1'b0;
    checkOutput("simul dm latency", lat_dm, 3);
    checkOutput("simul if latency", lat_if, 7);
    checkOutput("simul dm_data", dm_data, 16'h0326);
    checkOutput("simul if_data", if_data, 16'h0102);
    checkOutput("simul first grant", grant_log[g], 16'h0004);
    checkOutput("simul second grant", grant_log[g + 1], 16'h0002);
    tick();
    tick();

    $display("[TB] back-to-back request streams on both ports");
    g     = grant_cnt;
    to_dm = 0;
    to_if = 0;
    fork
      begin
        for (int k = 0; k < 4; k++) begin
          int n_dm;
          dm_addr = 16'h0004;
          dm_re   = 1'b1;
          n_dm    = 0;
          @(negedge clk);
          while (dm_need_wait && n_dm < 100) begin
            @(negedge clk);
            n_dm++;
          end
          if (dm_need_wait) to_dm++;
          dm_re = 1'b0;
          tick();
        end
      end
      begin
        for (int k = 0; k < 4; k++) begin
          int n_if;
          if_addr = 16'h0002;
          if_re   = 1'b1;
          n_if    = 0;
          @(negedge clk);
          while (if_need_wait && n_if < 100) begin
            @(negedge clk);
            n_if++;
          end
          if (if_need_wait) to_if++;
          if_re = 1'b0;
          tick();
        end
      end
    join
    tick();
    checkOutput("stream dm timeouts", to_dm, 0);
    checkOutput("stream if timeouts", to_if, 0);
    checkOutput("stream grant count", grant_cnt - g, 8);
    for (int k = 0; k < 8; k++) begin
      checkOutput($sformatf("stream grant %0d", k), grant_log[g + k], exp_order[k]);
    end
    checkOutput("stream dm_data", dm_data, 16'h0326);
    checkOutput("stream if_data", if_data, 16'h0102);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
